multi_duplicate_fifo: RTL and testbench
=======================================

Name: multi_duplicate_fifo

Overview:
- Parametrised successor to the duplicate FIFO.
- Each pushed word carries its own repeat count, so the read side delivers that word 1..MAX_REP times before advancing to the next entry.
- Adds occupancy output, last-copy indication, simultaneous push/pop on full, and sticky overflow/underflow flags with clear.
- Sits between a producer and a consumer that needs replayed words (e.g. upsampling or duplicate transmission).

Parameters:
- DW, 16, data width in bits.
- DEPTH, 4, number of entries (≥2, need not be a power of two).
- MAX_REP, 4, maximum copies per entry (≥2).
- RW, $clog2(MAX_REP), width of the repeat field (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write request.
- write_data  input  DW  word to store.
- write_rep  input  RW  copies minus one; delivered copies = min(write_rep, MAX_REP-1)+1.
- full  output  1  count == DEPTH.
- pop  input  1  consume one copy of the head word.
- read_data  output  DW  head word, first-word-fall-through; valid when !empty.
- read_last  output  1  current copy is the final copy of the head entry.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  stored entries (not copies).
- clr_err  input  1  synchronous clear of the sticky flags.
- overflow  output  1  sticky: push was dropped.
- underflow  output  1  sticky: pop was issued while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr, count and served all go to 0.
  - empty=1, full=0, read_last=0, overflow=0, underflow=0.
  - read_data=0; mem is not cleared.
- Storage: mem entries hold {rep, data}; rep is saturated at write time.
- Head outputs: read_data = mem[rd_ptr].data. read_last = !empty && (served == mem[rd_ptr].rep). All outputs are combinational from registers.
- pop accepted (pop && !empty):
  - If read_last: rd_ptr advances with wrap DEPTH-1→0, served←0, count decrements.
  - Otherwise served increments and rd_ptr holds.
- push accepted = push && (!full || (pop && read_last)). On accept: write mem[wr_ptr], wr_ptr advances with wrap, count increments.
- Same-cycle push and final pop: count is unchanged.
  - On full this allows push; the new word lands in the freed slot (wr_ptr == rd_ptr before the update).
- Push while full without a final pop: word dropped, overflow←1.
- Pop while empty: ignored, underflow←1.
- Push+pop while empty: push is accepted; the pop is ignored and sets underflow (no bypass). The word is visible the next cycle.
- clr_err=1 clears both sticky flags. A new error in the same cycle wins (flag set).
- Latency: a pushed word appears on read_data one cycle after the push edge when the FIFO was empty.
- A non-final pop never changes count, full or empty.
- Reset mid-replay discards all entries and the served progress.

Decomposition:
- Package duplicate_pkg holds the clamp_rep function (saturation to MAX_REP-1), a parametrised entry struct helper, and CNT_W/RW width-calculation constants.
- Sub-module dup_fifo_mem: DEPTH×(DW+RW) register array with a synchronous write port and an asynchronous read port, no reset.
- Pointer, count, served and flag logic live in the top module.

Test Plan (DW=16, DEPTH=4, MAX_REP=4):
- Reset, then push 7 with rep=1 and push 9 with rep=0 -> reads give 7 (last=0), 7 (last=1), 9 (last=1); then empty=1 and count=0.
- Push 1,2,3,4 with rep=0, then push 5 -> full=1, count=4, overflow=1; 5 is dropped; four pops return 1,2,3,4.
- Fill 4 entries with rep=0 and issue clr_err; on full, push 21 with a pop of head 1 -> count stays 4, full stays 1, no overflow; later reads return 2,3,4,21.
- Full with head rep=2, push 30 with a non-final pop -> 30 dropped, overflow=1, count=4, read_data unchanged.
- Pop while empty -> underflow=1 and state unchanged; clr_err next cycle -> underflow=0. Push 8 with rep=3 (saturates to 3) -> four reads of 8 and read_last only on the fourth.
- Push 5 entries across wrap (push/pop interleaved 10 times), then assert rst mid-replay of an entry with rep=3 -> empty=1, count=0, read_last=0 immediately (asynchronous); the next push/pop delivers only new data.

Source files
------------

// File: rtl/duplicate_pkg.sv
// Shared widths and helpers for the multi-copy replay FIFO.
package duplicate_pkg;

    // Default configuration, used for the reference entry layout below.
    localparam int unsigned DEF_DW      = 16;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_MAX_REP = 4;

    // Width of the per-entry repeat field (copies minus one).
    function automatic int unsigned rep_width(input int unsigned max_rep);
        return $clog2(max_rep);
    endfunction

    // Width of an occupancy counter that must also represent DEPTH itself.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a stored entry: repeat field above the data word.
    function automatic int unsigned entry_width(input int unsigned dw, input int unsigned max_rep);
        return dw + rep_width(max_rep);
    endfunction

    // Saturate a requested repeat value to the largest legal one.
    function automatic int unsigned clamp_rep(input int unsigned rep, input int unsigned max_rep);
        return (rep > max_rep - 1) ? (max_rep - 1) : rep;
    endfunction

    localparam int unsigned DEF_RW    = rep_width(DEF_MAX_REP);
    localparam int unsigned DEF_CNT_W = cnt_width(DEF_DEPTH);

    // Entry layout for the default configuration; the generic top packs the
    // same {rep, data} order into a flat vector.
    typedef struct packed {
        logic [DEF_RW-1:0] rep;
        logic [DEF_DW-1:0] data;
    } entry_t;

endpackage

// File: rtl/dup_fifo_mem.sv
// Entry storage: synchronous write, asynchronous read, deliberately not reset.
module dup_fifo_mem #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port: one entry per accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/multi_duplicate_fifo.sv
// FIFO whose head word is replayed a per-entry number of times before advancing.
module multi_duplicate_fifo
    import duplicate_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned MAX_REP = 4,
    parameter int unsigned RW      = rep_width(MAX_REP)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                write_data,
    input  logic [RW-1:0]                write_rep,
    output logic                         full,
    input  logic                         pop,
    output logic [DW-1:0]                read_data,
    output logic                         read_last,
    output logic                         empty,
    output logic [cnt_width(DEPTH)-1:0]  count,
    input  logic                         clr_err,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned EW    = entry_width(DW, MAX_REP);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [RW-1:0]    served;
    logic [EW-1:0]    wr_entry;
    logic [EW-1:0]    rd_entry;
    logic [RW-1:0]    head_rep;
    logic             pop_ok;
    logic             pop_final;
    logic             push_ok;

    // Advance a pointer with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    dup_fifo_mem #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign wr_entry  = {RW'(clamp_rep(32'(write_rep), MAX_REP)), write_data};
    assign head_rep  = rd_entry[EW-1:DW];

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign read_data = empty ? '0 : rd_entry[DW-1:0];
    assign read_last = !empty && (served == head_rep);

    // A final pop frees the head slot, so a push may land there even when full.
    assign pop_ok    = pop && !empty;
    assign pop_final = pop_ok && read_last;
    assign push_ok   = push && (!full || pop_final);

    // Pointers, occupancy and replay progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            served <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop_final) begin
                rd_ptr <= next_ptr(rd_ptr);
                served <= '0;
            end else if (pop_ok) begin
                served <= served + RW'(1);
            end
            case ({push_ok, pop_final})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_duplicate_fifo.sv
// Directed self-checking bench for multi_duplicate_fifo (DW=16, DEPTH=4, MAX_REP=4).
module tb_multi_duplicate_fifo;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] write_data;
    logic [1:0]  write_rep;
    logic        full;
    logic        pop;
    logic [15:0] read_data;
    logic        read_last;
    logic        empty;
    logic [2:0]  count;
    logic        clr_err;
    logic        overflow;
    logic        underflow;

    int compared;
    int mismatched;

    multi_duplicate_fifo #(
        .DW      (16),
        .DEPTH   (4),
        .MAX_REP (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .write_data (write_data),
        .write_rep  (write_rep),
        .full       (full),
        .pop        (pop),
        .read_data  (read_data),
        .read_last  (read_last),
        .empty      (empty),
        .count      (count),
        .clr_err    (clr_err),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic [15:0] d, input logic [1:0] r,
                       input logic po, input logic c);
        push       = p;
        write_data = d;
        write_rep  = r;
        pop        = po;
        clr_err    = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clr_err    = 1'b0;
        write_data = '0;
        write_rep  = '0;

        // Reset state
        #23;
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_count", 32'(count), 0);
        check("rst_last", 32'(read_last), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_unf", 32'(underflow), 0);
        check("rst_data", 32'(read_data), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Mixed repeat counts: 7 twice, 9 once
        cyc(1, 16'd7, 2'd1, 0, 0);
        check("t1_latency_data", 32'(read_data), 7);
        cyc(1, 16'd9, 2'd0, 0, 0);
        check("t1_count", 32'(count), 2);
        check("t1_d0", 32'(read_data), 7);
        check("t1_l0", 32'(read_last), 0);
        cyc(0, 0, 0, 1, 0);
        check("t1_d1", 32'(read_data), 7);
        check("t1_l1", 32'(read_last), 1);
        check("t1_cnt_nonfinal", 32'(count), 2);
        cyc(0, 0, 0, 1, 0);
        check("t1_d2", 32'(read_data), 9);
        check("t1_l2", 32'(read_last), 1);
        check("t1_count1", 32'(count), 1);
        cyc(0, 0, 0, 1, 0);
        check("t1_empty", 32'(empty), 1);
        check("t1_count0", 32'(count), 0);

        // Fill to full then overflow
        for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 2'd0, 0, 0);
        check("t2_full", 32'(full), 1);
        check("t2_count", 32'(count), 4);
        check("t2_ovf_before", 32'(overflow), 0);
        cyc(1, 16'd5, 2'd0, 0, 0);
        check("t2_full_after", 32'(full), 1);
        check("t2_count_after", 32'(count), 4);
        check("t2_ovf", 32'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            check("t2_read", 32'(read_data), 32'(i));
            cyc(0, 0, 0, 1, 0);
        end
        check("t2_drained", 32'(empty), 1);

        // Push with final pop on full
        for (int i = 1; i <= 4; i++) cyc(1, 16'(i), 2'd0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        check("t3_ovf_clr", 32'(overflow), 0);
        cyc(1, 16'd21, 2'd0, 1, 0);
        check("t3_count", 32'(count), 4);
        check("t3_full", 32'(full), 1);
        check("t3_ovf", 32'(overflow), 0);
        begin
            logic [15:0] exp3 [4];
            exp3[0] = 16'd2; exp3[1] = 16'd3; exp3[2] = 16'd4; exp3[3] = 16'd21;
            for (int i = 0; i < 4; i++) begin
                check("t3_read", 32'(read_data), 32'(exp3[i]));
                cyc(0, 0, 0, 1, 0);
            end
        end
        check("t3_drained", 32'(empty), 1);

        // Full with multi-copy head: non-final pop does not free a slot
        cyc(1, 16'd40, 2'd2, 0, 0);
        for (int i = 41; i <= 43; i++) cyc(1, 16'(i), 2'd0, 0, 0);
        check("t4_full", 32'(full), 1);
        cyc(1, 16'd30, 2'd0, 1, 0);
        check("t4_ovf", 32'(overflow), 1);
        check("t4_count", 32'(count), 4);
        check("t4_data", 32'(read_data), 16'd40);
        check("t4_last", 32'(read_last), 0);
        cyc(0, 0, 0, 1, 0);
        check("t4_last2", 32'(read_last), 1);
        check("t4_data2", 32'(read_data), 16'd40);
        cyc(0, 0, 0, 1, 0);
        for (int i = 41; i <= 43; i++) begin
            check("t4_read", 32'(read_data), 32'(i));
            cyc(0, 0, 0, 1, 0);
        end
        check("t4_drained", 32'(empty), 1);

        // Underflow, clear, saturated repeat
        cyc(0, 0, 0, 1, 0);
        check("t5_unf", 32'(underflow), 1);
        check("t5_empty", 32'(empty), 1);
        check("t5_count", 32'(count), 0);
        cyc(0, 0, 0, 0, 1);
        check("t5_unf_clr", 32'(underflow), 0);
        check("t5_ovf_clr", 32'(overflow), 0);
        cyc(1, 16'd8, 2'd3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("t5_data", 32'(read_data), 8);
            check("t5_last", 32'(read_last), (i == 3) ? 1 : 0);
            cyc(0, 0, 0, 1, 0);
        end
        check("t5_drained", 32'(empty), 1);

        // Pointer wrap via interleaved push/pop, then reset mid-replay
        for (int i = 0; i < 5; i++) begin
            cyc(1, 16'(100 + i), 2'd0, 0, 0);
            check("t6_wrap_read", 32'(read_data), 32'(100 + i));
            cyc(0, 0, 0, 1, 0);
        end
        check("t6_unf", 32'(underflow), 0);
        cyc(1, 16'd200, 2'd3, 0, 0);
        cyc(1, 16'd201, 2'd0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("t6_mid_data", 32'(read_data), 200);
        check("t6_mid_last", 32'(read_last), 0);
        check("t6_mid_count", 32'(count), 2);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_empty", 32'(empty), 1);
        check("t6_rst_count", 32'(count), 0);
        check("t6_rst_last", 32'(read_last), 0);
        check("t6_rst_data", 32'(read_data), 0);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 16'd300, 2'd0, 0, 0);
        check("t6_new_data", 32'(read_data), 300);
        check("t6_new_last", 32'(read_last), 1);
        check("t6_new_count", 32'(count), 1);
        cyc(0, 0, 0, 1, 0);
        check("t6_new_empty", 32'(empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
